matriz_varredura: RTL and testbench

MATRIZ_VARREDURA -- requirements
Module: matriz_varredura

---
 rtl/matriz_varredura.sv | 139 +++++++++++++
 tb/tb_matriz_varredura.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/matriz_varredura.sv
// Row-multiplexed LED matrix scanner: stores N_IMG images, scans one row per
// SCAN_DIV cycles, swaps images only at frame boundaries, optionally blinks.
module matriz_varredura #(
  parameter int unsigned ROWS         = 7,
  parameter int unsigned COLS         = 5,
  parameter int unsigned N_IMG        = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  logic [((N_IMG > 1) ? $clog2(N_IMG) : 1)-1:0]  img_sel,
  input  logic                                          blink_en,
  input  logic                                          wr_en,
  input  logic [((N_IMG > 1) ? $clog2(N_IMG) : 1)-1:0]  wr_img,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    wr_row,
  input  logic [COLS-1:0]                               wr_data,
  output logic [ROWS-1:0]                               lin,
  output logic [COLS-1:0]                               col,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    row_idx,
  output logic                                          frame_done
);

  localparam int unsigned IMG_W = (N_IMG > 1) ? $clog2(N_IMG) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW    = $clog2(2 * BLINK_FRAMES);

  // Power-on glyphs exist only for the 7x5 geometry; anything else clears to zero.
  function automatic logic [COLS-1:0] dflt_word(int unsigned img, int unsigned r);
    logic [4:0] w;
    w = 5'b00000;
    case (img)
      0: w = (r == 6) ? 5'b11111 : 5'b10001;
      1: w = (r >= 4) ? 5'b11111 : 5'b10001;
      2: w = (r >= 2) ? 5'b11111 : 5'b10001;
      3: w = 5'b11111;
      4: case (r)
           1, 4, 5: w = 5'b00100;
           2:       w = 5'b10101;
           3:       w = 5'b01010;
           6:       w = 5'b11111;
           default: w = 5'b00000;
         endcase
      5: case (r)
           1, 2, 6: w = 5'b00100;
           3, 5:    w = 5'b01110;
           4:       w = 5'b11111;
           default: w = 5'b00000;
         endcase
      default: w = 5'b00000;
    endcase
    if (ROWS == 7 && COLS == 5) return COLS'(w);
    return '0;
  endfunction

  logic [COLS-1:0]  mem_q [N_IMG][ROWS];
  logic [COLS-1:0]  mem_d [N_IMG][ROWS];
  logic [DW-1:0]    div_q, div_d;
  logic [RW-1:0]    row_q, row_d;
  logic [IMG_W-1:0] act_img_q, act_img_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic [ROWS-1:0]  lin_d;
  logic [COLS-1:0]  col_d;
  logic [RW-1:0]    row_idx_d;
  logic             frame_done_d;
  logic             div_wrap, frame_end, sel_ok, blank;

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (32'(wr_img) < N_IMG) && (32'(wr_row) < ROWS)) begin
      mem_d[wr_img][wr_row] = wr_data;
    end
  end

  // Scan position, image latch and blink phase.
  always_comb begin
    div_wrap  = (div_q == DW'(SCAN_DIV - 1));
    frame_end = div_wrap && (row_q == RW'(ROWS - 1));
    sel_ok    = (32'(img_sel) < N_IMG);
    div_d     = div_q;
    row_d     = row_q;
    act_img_d = act_img_q;
    blink_d   = blink_q;
    if (!enable) begin
      div_d   = '0;
      row_d   = '0;
      blink_d = '0;
      if (sel_ok) act_img_d = img_sel;
    end else begin
      div_d = div_wrap ? '0 : div_q + DW'(1);
      if (div_wrap) row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      if (frame_end) begin
        if (sel_ok) act_img_d = img_sel;
        blink_d = (blink_q == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_q + BW'(1);
      end
    end
    if (!blink_en) blink_d = '0;
  end

  // First slot of every row stays dark so the previous row does not ghost.
  always_comb begin
    blank        = !enable || (div_q == '0) || (blink_en && (blink_q >= BW'(BLINK_FRAMES)));
    lin_d        = blank ? '1 : ~(ROWS'(1) << row_q);
    col_d        = blank ? '0 : mem_q[act_img_q][row_q];
    row_idx_d    = row_q;
    frame_done_d = enable && frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IMG; i++) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          mem_q[i][r] <= dflt_word(i, r);
        end
      end
      div_q      <= '0;
      row_q      <= '0;
      act_img_q  <= '0;
      blink_q    <= '0;
      lin        <= '1;
      col        <= '0;
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      div_q      <= div_d;
      row_q      <= row_d;
      act_img_q  <= act_img_d;
      blink_q    <= blink_d;
      lin        <= lin_d;
      col        <= col_d;
      row_idx    <= row_idx_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_matriz_varredura.sv
// Bench for matriz_varredura: frame-time behavioural model checked every cycle,
// plus directed literal checks on image swap, blink, write, reset and enable.
module tb_matriz_varredura;
  localparam int ROWS = 7, COLS = 5, N_IMG = 8, SD = 4, BF = 2;
  localparam int FR = SD * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1, blink_en = 1'b0, wr_en = 1'b0;
  logic [2:0] img_sel = 3'd3, wr_img = 3'd0, wr_row = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [6:0] lin;
  logic [4:0] col;
  logic [2:0] row_idx;
  logic frame_done;

  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  matriz_varredura #(.ROWS(ROWS), .COLS(COLS), .N_IMG(N_IMG), .SCAN_DIV(SD),
                     .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .img_sel(img_sel),
    .blink_en(blink_en), .wr_en(wr_en), .wr_img(wr_img), .wr_row(wr_row),
    .wr_data(wr_data), .lin(lin), .col(col), .row_idx(row_idx),
    .frame_done(frame_done));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [4:0] dflt(int i, int r);
    logic [34:0] v;
    case (i)
      0: v = {5'b11111, {6{5'b10001}}};
      1: v = {{3{5'b11111}}, {4{5'b10001}}};
      2: v = {{5{5'b11111}}, {2{5'b10001}}};
      3: v = {7{5'b11111}};
      4: v = {5'b11111, 5'b00100, 5'b00100, 5'b01010, 5'b10101, 5'b00100, 5'b00000};
      5: v = {5'b00100, 5'b01110, 5'b11111, 5'b01110, 5'b00100, 5'b00100, 5'b00000};
      default: v = '0;
    endcase
    return v[5*r +: 5];
  endfunction

  // Model: scan time t since start; row/slot/frame derived arithmetically.
  int mt, mfc, mact;
  logic [4:0] mm [N_IMG][ROWS];
  logic [6:0] e_lin;
  logic [4:0] e_col;
  int e_row;
  logic e_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt = 0; mfc = 0; mact = 0;
      for (int i = 0; i < N_IMG; i++)
        for (int r = 0; r < ROWS; r++) mm[i][r] = dflt(i, r);
      e_lin = 7'h7f; e_col = 5'd0; e_row = 0; e_fd = 1'b0;
    end else begin
      int dv, rw;
      bit blank, bnd;
      dv = mt % SD;
      rw = (mt / SD) % ROWS;
      bnd = ((mt + 1) % FR) == 0;
      blank = !enable || dv == 0 || (blink_en && mfc >= BF);
      e_lin = blank ? 7'h7f : ~(7'd1 << rw);
      e_col = blank ? 5'd0 : mm[mact][rw];
      e_row = rw;
      e_fd = enable && bnd;
      if (wr_en && wr_row < 3'd7) mm[wr_img][wr_row] = wr_data;
      if (!enable) begin
        mt = 0; mfc = 0; mact = int'(img_sel);
      end else begin
        mt++;
        if (bnd) begin
          mact = int'(img_sel);
          if (blink_en) mfc = (mfc + 1) % (2 * BF);
        end
      end
      if (!blink_en) mfc = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_lin", lin, e_lin);
      chk("model_col", col, e_col);
      chk("model_row_idx", row_idx, e_row);
      chk("model_frame_done", frame_done, e_fd);
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_out(input string nm, input logic [6:0] l, input logic [4:0] c);
    chk({nm, "_lin"}, lin, l);
    chk({nm, "_col"}, col, c);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk_out("reset", 7'h7f, 5'd0);
    chk("reset_row_idx", row_idx, 0);
    chk("reset_fd", frame_done, 0);
    @(negedge clk); rst_n = 1'b1; cyc = 0; chk_en = 1'b1;

    step_to(2);   chk_out("f0_row0", 7'b1111110, 5'b10001);
    chk("f0_row_idx", row_idx, 0);
    step_to(26);  chk_out("f0_row6", 7'b0111111, 5'b11111);
    step_to(28);  chk("f0_done", frame_done, 1);
    step_to(29);  chk("f1_done_low", frame_done, 0);
    chk_out("f1_blank_slot", 7'h7f, 5'd0);
    step_to(30);  chk_out("f1_row0_img3", 7'b1111110, 5'b11111);

    step_to(37);  img_sel = 3'd4;
    step_to(42);  chk_out("f1_row3_still_img3", 7'b1110111, 5'b11111);
    step_to(66);  chk_out("f2_row2_img4", 7'b1111011, 5'b10101);
    step_to(70);  chk_out("f2_row3_img4", 7'b1110111, 5'b01010);
    img_sel = 3'd3;

    step_to(85);  blink_en = 1'b1;
    step_to(114); chk_out("blink_lit_f4", 7'b1111110, 5'b11111);
    step_to(142); chk_out("blink_dark_f5", 7'h7f, 5'd0);
    step_to(171); chk_out("blink_dark_f6", 7'h7f, 5'd0);
    step_to(198); chk_out("blink_lit_f7", 7'b1111110, 5'b11111);
    step_to(200); blink_en = 1'b0;
    step_to(254); chk_out("noblink_f9", 7'b1111110, 5'b11111);

    step_to(273); wr_en = 1'b1; wr_img = 3'd3; wr_row = 3'd5; wr_data = 5'b01010;
    step_to(274); wr_en = 1'b0;
    step_to(275); chk_out("write_row5", 7'b1011111, 5'b01010);
    step_to(298); chk_out("write_row4_kept", 7'b1101111, 5'b11111);
    step_to(302); chk_out("write_row5_next", 7'b1011111, 5'b01010);
    step_to(306); chk_out("write_row6_kept", 7'b0111111, 5'b11111);

    step_to(326);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 7'h7f, 5'd0);
    chk("async_reset_fd", frame_done, 0);
    chk("async_reset_row_idx", row_idx, 0);
    step_to(328);
    rst_n = 1'b1; cyc = 0;
    step_to(2);  chk_out("post_reset_img0", 7'b1111110, 5'b10001);
    step_to(50); chk_out("post_reset_img3_row5", 7'b1011111, 5'b11111);

    step_to(70); enable = 1'b0; img_sel = 3'd5;
    step_to(72); chk_out("disabled", 7'h7f, 5'd0);
    chk("disabled_fd", frame_done, 0);
    step_to(80); enable = 1'b1; cyc = 0;
    step_to(2);  chk_out("resume_row0", 7'b1111110, 5'b00000);
    chk("resume_row_idx", row_idx, 0);
    step_to(6);  chk_out("resume_row1_img5", 7'b1111101, 5'b00100);
    step_to(14); chk_out("resume_row3_img5", 7'b1110111, 5'b01110);
    step_to(40);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
